fitness_sched: RTL
==================

FITNESS_SCHED -- requirements
Module: fitness_sched

Interface
REQ-001 Parameter N_POP, default 50, number of individuals in the population.
REQ-002 Parameter DIST_W, default 12, width of one distance value.
REQ-003 Parameter IDX_W, default 6, width of an individual index.
REQ-004 Parameter TIMEOUT_CYC, default 4096, watchdog limit in WAIT, in cycles.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 go  in  1  request one fitness evaluation of the current population.
REQ-008 cd_start  out  1  one-cycle launch pulse to the distance array.
REQ-009 cd_done  in  1  AND of all distance-unit done flags.
REQ-010 distances  in  N_POP*DIST_W  packed distances; individual i at bits [i*DIST_W +: DIST_W].
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse when results are valid.
REQ-013 best_idx / best_dist  out  IDX_W / DIST_W  index and distance of the smallest distance.
REQ-014 second_idx / second_dist  out  IDX_W / DIST_W  index and distance of the second smallest distance.
REQ-015 timeout  out  1  sticky until next accepted go; evaluation aborted by the watchdog.

Function
REQ-016 States SHALL be IDLE, LAUNCH, WAIT, SCAN, REPORT.
- IDLE->LAUNCH when go=1.
- LAUNCH->WAIT unconditionally.
- WAIT->SCAN on the armed cd_done rise.
- SCAN->REPORT after index N_POP-1.
- REPORT->IDLE unconditionally.
REQ-017 go SHALL be ignored while busy=1; no queuing.
REQ-018 cd_start SHALL be high exactly in the LAUNCH cycle.
REQ-019 WAIT SHALL arm only after sampling cd_done=0 at least once; cd_done=1 seen before arming (stale done) SHALL be ignored.
REQ-020 On leaving WAIT, distances SHALL be snapshotted into an internal register; SCAN reads only the snapshot.
REQ-021 SCAN SHALL examine one individual per cycle, index 0..N_POP-1, taking exactly N_POP cycles.
REQ-022 Comparison SHALL be unsigned strict less-than; on equal distances, the lower index keeps the higher rank.
REQ-023 Top-two update:
- d < best: old best moves to second, d becomes best.
- else d < second: d becomes second.
REQ-024 Trackers SHALL initialise to best_dist = second_dist = all-ones and idx = all-ones at SCAN entry.
REQ-025 Result outputs SHALL update only in REPORT; done SHALL pulse in the REPORT cycle.
REQ-026 Results SHALL hold their values until the next REPORT.
REQ-027 Latency go->done SHALL be 1 (LAUNCH) + WAIT length + 1 (snapshot) + N_POP (SCAN) + 1 cycles.
REQ-028 cd_done changes during SCAN/REPORT SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately, including mid-evaluation.
REQ-030 Reset values: cd_start=0, busy=0, done=0, timeout=0, best/second idx = all-ones, best/second dist = all-ones.
REQ-031 After reset deassertion, the first go SHALL be accepted in the first IDLE cycle.

Configuration
REQ-032 Macro FITNESS_SCHED_WATCHDOG_EN.
- Defined: a WAIT cycle counter runs. At TIMEOUT_CYC cycles without an armed cd_done, the block SHALL go to REPORT with timeout=1 and results set to all-ones; done still pulses.
- Undefined: no counter is present, WAIT is unbounded, and timeout is tied 0.

Structure
REQ-033 Package ga_pkg SHALL hold N_POP, DIST_W, IDX_W, GENOME_W (150), the state enum, and the all-ones sentinel constants.
REQ-034 The top-two compare/update SHALL be a combinational sub-module min2_tracker (inputs: current best/second, candidate d/idx; outputs: next best/second).

Verification
REQ-035 distances all 100 except idx 7=5 and idx 42=9; go, cd_done rises 20 cycles after cd_start -> best 7/5, second 42/9, done exactly once, latency 20+53 cycles.
REQ-036 All distances 300 -> best_idx=0, second_idx=1, both dist 300 (tie rule).
REQ-037 cd_done held 1 before go -> no SCAN until cd_done has dropped and risen again; go pulsed during busy -> ignored, single done.
REQ-038 With FITNESS_SCHED_WATCHDOG_EN, cd_done never rises -> done after TIMEOUT_CYC WAIT cycles, timeout=1, results all-ones; next go clears timeout.
REQ-039 rst_n low for 1 cycle mid-SCAN at index 25 -> immediately IDLE with all reset values, no done; the subsequent go completes normally.
REQ-040 Distances change after snapshot during SCAN (idx 3 set to 0) -> results reflect the snapshot values only.

Source files
------------

// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared constants, sentinels and state encoding for the fitness scheduler
package ga_pkg;

    localparam int N_POP    = 50;
    localparam int DIST_W   = 12;
    localparam int IDX_W    = 6;
    localparam int GENOME_W = 150;

    // "No candidate yet" markers for the top-two trackers and the timeout result.
    localparam logic [DIST_W-1:0] DIST_ONES = '1;
    localparam logic [IDX_W-1:0]  IDX_ONES  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_SCAN,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/min2_tracker.sv
// rtl/min2_tracker.sv - combinational top-two (smallest) distance update
//
// Ports:
//   best_dist/best_idx, second_dist/second_idx : current ranking
//   cand_dist/cand_idx                         : candidate individual
//   nxt_*                                      : ranking after considering the candidate
// Strict less-than keeps an earlier (lower-index) individual ahead on ties.
module min2_tracker #(
    parameter int DIST_W = ga_pkg::DIST_W,
    parameter int IDX_W  = ga_pkg::IDX_W
) (
    input  logic [DIST_W-1:0] best_dist,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DIST_W-1:0] second_dist,
    input  logic [IDX_W-1:0]  second_idx,
    input  logic [DIST_W-1:0] cand_dist,
    input  logic [IDX_W-1:0]  cand_idx,
    output logic [DIST_W-1:0] nxt_best_dist,
    output logic [IDX_W-1:0]  nxt_best_idx,
    output logic [DIST_W-1:0] nxt_second_dist,
    output logic [IDX_W-1:0]  nxt_second_idx
);

    always_comb begin
        nxt_best_dist   = best_dist;
        nxt_best_idx    = best_idx;
        nxt_second_dist = second_dist;
        nxt_second_idx  = second_idx;
        if (cand_dist < best_dist) begin
            nxt_second_dist = best_dist;
            nxt_second_idx  = best_idx;
            nxt_best_dist   = cand_dist;
            nxt_best_idx    = cand_idx;
        end else if (cand_dist < second_dist) begin
            nxt_second_dist = cand_dist;
            nxt_second_idx  = cand_idx;
        end
    end

endmodule

// File: rtl/fitness_sched.sv
// rtl/fitness_sched.sv - sequences one population fitness evaluation and ranks the two best
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   go                    : start an evaluation (ignored while busy)
//   cd_start / cd_done    : launch pulse to / completion from the distance array
//   distances             : packed distances, individual i at [i*DIST_W +: DIST_W]
//   busy, done            : not-idle flag, one-cycle result-valid pulse
//   best_* / second_*     : index and distance of the smallest / second smallest
//   timeout               : evaluation aborted by the WAIT watchdog (sticky until next go)
// Build option: define FITNESS_SCHED_WATCHDOG_EN to bound WAIT to TIMEOUT_CYC cycles.
module fitness_sched
    import ga_pkg::*;
#(
    parameter int N_POP       = ga_pkg::N_POP,
    parameter int DIST_W      = ga_pkg::DIST_W,
    parameter int IDX_W       = ga_pkg::IDX_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    output logic                    cd_start,
    input  logic                    cd_done,
    input  logic [N_POP*DIST_W-1:0] distances,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        best_idx,
    output logic [DIST_W-1:0]       best_dist,
    output logic [IDX_W-1:0]        second_idx,
    output logic [DIST_W-1:0]       second_dist,
    output logic                    timeout
);

    state_t                  state_q, state_d;
    logic                    cd_done_q, cd_done_d;
    logic                    armed_q, armed_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [N_POP*DIST_W-1:0] snap_q, snap_d;
    logic [DIST_W-1:0]       trk_bd_q, trk_bd_d, trk_sd_q, trk_sd_d;
    logic [IDX_W-1:0]        trk_bi_q, trk_bi_d, trk_si_q, trk_si_d;
    logic [DIST_W-1:0]       res_bd_q, res_bd_d, res_sd_q, res_sd_d;
    logic [IDX_W-1:0]        res_bi_q, res_bi_d, res_si_q, res_si_d;
    logic                    timeout_q, timeout_d;
    logic                    busy_q, busy_d, done_q, done_d, cd_start_q, cd_start_d;

    logic [DIST_W-1:0]       nxt_bd, nxt_sd, cand_dist;
    logic [IDX_W-1:0]        nxt_bi, nxt_si;

`ifdef FITNESS_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    assign cand_dist = snap_q[int'(scan_idx_q)*DIST_W +: DIST_W];

    min2_tracker #(.DIST_W(DIST_W), .IDX_W(IDX_W)) u_min2 (
        .best_dist       (trk_bd_q),
        .best_idx        (trk_bi_q),
        .second_dist     (trk_sd_q),
        .second_idx      (trk_si_q),
        .cand_dist       (cand_dist),
        .cand_idx        (scan_idx_q),
        .nxt_best_dist   (nxt_bd),
        .nxt_best_idx    (nxt_bi),
        .nxt_second_dist (nxt_sd),
        .nxt_second_idx  (nxt_si)
    );

    always_comb begin
        state_d    = state_q;
        cd_done_d  = cd_done;   // cd_done is a wide AND from the array; take it through a flop
        armed_d    = armed_q;
        scan_idx_d = scan_idx_q;
        snap_d     = snap_q;
        trk_bd_d   = trk_bd_q;
        trk_bi_d   = trk_bi_q;
        trk_sd_d   = trk_sd_q;
        trk_si_d   = trk_si_q;
        res_bd_d   = res_bd_q;
        res_bi_d   = res_bi_q;
        res_sd_d   = res_sd_q;
        res_si_d   = res_si_q;
        timeout_d  = timeout_q;
`ifdef FITNESS_SCHED_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d   = ST_LAUNCH;
                    timeout_d = 1'b0;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                armed_d = 1'b0;
`ifdef FITNESS_SCHED_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                // A done level left over from a previous run must drop before it counts.
                if (armed_q && cd_done_q) begin
                    state_d    = ST_SCAN;
                    snap_d     = distances;
                    scan_idx_d = '0;
                    trk_bd_d   = '1;
                    trk_bi_d   = '1;
                    trk_sd_d   = '1;
                    trk_si_d   = '1;
                end else begin
                    if (!cd_done_q) armed_d = 1'b1;
`ifdef FITNESS_SCHED_WATCHDOG_EN
                    if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        state_d   = ST_REPORT;
                        timeout_d = 1'b1;
                        res_bd_d  = '1;
                        res_bi_d  = '1;
                        res_sd_d  = '1;
                        res_si_d  = '1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_SCAN: begin
                trk_bd_d   = nxt_bd;
                trk_bi_d   = nxt_bi;
                trk_sd_d   = nxt_sd;
                trk_si_d   = nxt_si;
                scan_idx_d = scan_idx_q + 1'b1;
                if (scan_idx_q == IDX_W'(N_POP - 1)) begin
                    state_d  = ST_REPORT;
                    res_bd_d = nxt_bd;
                    res_bi_d = nxt_bi;
                    res_sd_d = nxt_sd;
                    res_si_d = nxt_si;
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        busy_d     = (state_d != ST_IDLE);
        cd_start_d = (state_d == ST_LAUNCH);
        done_d     = (state_d == ST_REPORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cd_done_q  <= 1'b0;
            armed_q    <= 1'b0;
            scan_idx_q <= '0;
            snap_q     <= '0;
            trk_bd_q   <= '1;
            trk_bi_q   <= '1;
            trk_sd_q   <= '1;
            trk_si_q   <= '1;
            res_bd_q   <= '1;
            res_bi_q   <= '1;
            res_sd_q   <= '1;
            res_si_q   <= '1;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cd_start_q <= 1'b0;
`ifdef FITNESS_SCHED_WATCHDOG_EN
            wd_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cd_done_q  <= cd_done_d;
            armed_q    <= armed_d;
            scan_idx_q <= scan_idx_d;
            snap_q     <= snap_d;
            trk_bd_q   <= trk_bd_d;
            trk_bi_q   <= trk_bi_d;
            trk_sd_q   <= trk_sd_d;
            trk_si_q   <= trk_si_d;
            res_bd_q   <= res_bd_d;
            res_bi_q   <= res_bi_d;
            res_sd_q   <= res_sd_d;
            res_si_q   <= res_si_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cd_start_q <= cd_start_d;
`ifdef FITNESS_SCHED_WATCHDOG_EN
            wd_cnt_q   <= wd_cnt_d;
`endif
        end
    end

    assign cd_start    = cd_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign best_idx    = res_bi_q;
    assign best_dist   = res_bd_q;
    assign second_idx  = res_si_q;
    assign second_dist = res_sd_q;

endmodule
